// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller slice.
package irq_pkg;

  typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_CLAIMED} irq_state_t;

  localparam logic IRQ_MODE_LEVEL = 1'b0;
  localparam logic IRQ_MODE_EDGE  = 1'b1;

endpackage

// File: rtl/irq_sync_det.sv
// One interrupt channel: input synchroniser, polarity normalisation and
// level/edge event detection.
module irq_sync_det
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic pol,
  input  logic mode,
  output logic s,
  output logic evt
);

  logic synced;
  logic s_prev;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign synced = src;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= src;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // s is 1 whenever the source is in its active state, whatever its polarity
  assign s = ~(synced ^ pol);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev <= 1'b0;
    end else begin
      s_prev <= s;
    end
  end

  assign evt = (mode == IRQ_MODE_EDGE) ? (s & ~s_prev) : s;

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: pending register, lowest-index priority
// select and the request/claim/complete handshake driving the irq line.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [NUM_IRQ-1:0] cfg_mask,
  input  logic [NUM_IRQ-1:0] cfg_edge,
  input  logic [NUM_IRQ-1:0] cfg_pol,
  input  logic               claim,
  input  logic               complete,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending
);

  irq_state_t         state;
  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] evt;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] pend_next;
  logic [ID_W-1:0]    sel;
  logic               any;

  generate
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
      irq_sync_det #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_det (
        .clk (clk),
        .rst (rst),
        .src (irq_src[i]),
        .pol (cfg_pol[i]),
        .mode(cfg_edge[i]),
        .s   (s[i]),
        .evt (evt[i])
      );
    end
  endgenerate

  assign eligible = pending & cfg_mask;
  assign any      = |eligible;

  // Descending scan so the lowest eligible index is the last one written
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel = ID_W'(i);
    end
  end

  // A new event always beats a clear, so an edge landing on complete survives
  always_comb begin
    pend_next = pending;
    for (int i = 0; i < NUM_IRQ; i++) begin
      logic held;
      logic done;
      logic drop;
      held = (state == IRQ_CLAIMED) && (irq_id == ID_W'(i));
      done = held && complete;
      drop = (cfg_edge[i] == IRQ_MODE_LEVEL) && !s[i] && !held;
      pend_next[i] = evt[i] | (pending[i] & ~done & ~drop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IRQ_IDLE;
      irq     <= 1'b0;
      irq_id  <= '0;
      pending <= '0;
    end else begin
      pending <= pend_next;
      case (state)
        IRQ_IDLE: begin
          if (any) begin
            state  <= IRQ_REQ;
            irq    <= 1'b1;
            irq_id <= sel;
          end
        end
        IRQ_REQ: begin
          if (!any) begin
            state <= IRQ_IDLE;
            irq   <= 1'b0;
          end else if (claim) begin
            state <= IRQ_CLAIMED;
            irq   <= 1'b0;
          end else begin
            irq_id <= sel;
          end
        end
        IRQ_CLAIMED: begin
          irq <= 1'b0;
          if (complete) state <= IRQ_IDLE;
        end
        default: begin
          state <= IRQ_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with a behavioural reference model compared
// every cycle, plus literal checkpoints at the interesting moments.
module tb_irq_ctrl;

  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;
  localparam int SYNC    = 2;

  localparam int M_IDLE    = 0;
  localparam int M_REQ     = 1;
  localparam int M_CLAIMED = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_IRQ-1:0] irq_src;
  logic [NUM_IRQ-1:0] cfg_mask;
  logic [NUM_IRQ-1:0] cfg_edge;
  logic [NUM_IRQ-1:0] cfg_pol;
  logic               claim;
  logic               complete;
  logic               irq;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_IRQ-1:0] pending;

  int check_cnt = 0;
  int pass_cnt  = 0;
  bit chk_en    = 1'b0;

  logic [NUM_IRQ-1:0] m_pend;
  logic [NUM_IRQ-1:0] m_prev;
  logic               m_irq;
  int                 m_id;
  int                 m_state;
  logic [NUM_IRQ-1:0] hist[$];

  irq_ctrl #(
    .NUM_IRQ    (NUM_IRQ),
    .ID_W       (ID_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_src (irq_src),
    .cfg_mask(cfg_mask),
    .cfg_edge(cfg_edge),
    .cfg_pol (cfg_pol),
    .claim   (claim),
    .complete(complete),
    .irq     (irq),
    .irq_id  (irq_id),
    .pending (pending)
  );

  always #5 clk = ~clk;

  // Reference model: the source seen by detection is the raw input from SYNC
  // edges ago; pending/handshake follow the behavioural rules directly.
  always @(posedge clk) begin : model
    logic [NUM_IRQ-1:0] raw;
    logic [NUM_IRQ-1:0] s_now;
    logic [NUM_IRQ-1:0] evt;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] nxt;
    int                 sel_i;
    bit                 held;
    if (rst) begin
      m_pend  = '0;
      m_prev  = '0;
      m_irq   = 1'b0;
      m_id    = 0;
      m_state = M_IDLE;
      hist.delete();
      for (int k = 0; k < SYNC; k++) hist.push_front('0);
    end else begin
      raw = hist[SYNC-1];
      for (int i = 0; i < NUM_IRQ; i++) begin
        s_now[i] = cfg_pol[i] ? raw[i] : ~raw[i];
        evt[i]   = cfg_edge[i] ? (s_now[i] & ~m_prev[i]) : s_now[i];
      end
      elig  = m_pend & cfg_mask;
      sel_i = -1;
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (elig[i] && sel_i < 0) sel_i = i;
      end
      for (int i = 0; i < NUM_IRQ; i++) begin
        held   = (m_state == M_CLAIMED) && (m_id == i);
        nxt[i] = m_pend[i];
        if (held && complete) nxt[i] = 1'b0;
        if (!cfg_edge[i] && !s_now[i] && !held) nxt[i] = 1'b0;
        if (evt[i]) nxt[i] = 1'b1;
      end
      if (m_state == M_IDLE) begin
        if (sel_i >= 0) begin
          m_state = M_REQ;
          m_irq   = 1'b1;
          m_id    = sel_i;
        end
      end else if (m_state == M_REQ) begin
        if (sel_i < 0) begin
          m_state = M_IDLE;
          m_irq   = 1'b0;
        end else if (claim) begin
          m_state = M_CLAIMED;
          m_irq   = 1'b0;
        end else begin
          m_id = sel_i;
        end
      end else begin
        if (complete) m_state = M_IDLE;
      end
      m_pend = nxt;
      m_prev = s_now;
      hist.push_front(irq_src);
      void'(hist.pop_back());
    end
  end

  task automatic checkValue(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the reference model
  always @(negedge clk) begin
    if (chk_en) begin
      checkValue("cyc_irq", int'(irq), int'(m_irq));
      checkValue("cyc_irq_id", int'(irq_id), m_id);
      checkValue("cyc_pending", int'(pending), int'(m_pend));
    end
  end

  task automatic checkOutput(input string name, input logic e_irq, input int e_id,
                             input logic [NUM_IRQ-1:0] e_pend);
    check_cnt++;
    if (irq === e_irq && int'(irq_id) == e_id && pending === e_pend) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got irq=%b id=%0d pending=%h expected irq=%b id=%0d pending=%h",
               name, irq, irq_id, pending, e_irq, e_id, e_pend);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_IRQ-1:0] src, input logic [NUM_IRQ-1:0] mask,
                               input logic clm, input logic cmp, input int n);
    irq_src  = src;
    cfg_mask = mask;
    claim    = clm;
    complete = cmp;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < SYNC; k++) hist.push_front('0);
    m_pend   = '0;
    m_prev   = '0;
    m_irq    = 1'b0;
    m_id     = 0;
    m_state  = M_IDLE;
    // Channel 5 is a level, active-low source idling high; the rest are edge, active-high
    cfg_edge = 8'hDF;
    cfg_pol  = 8'hDF;
    rst      = 1'b1;
    applyStimulus(8'h20, 8'h00, 1'b0, 1'b0, 3);
    rst    = 1'b0;
    chk_en = 1'b1;
    checkOutput("reset", 1'b0, 0, 8'h00);
    applyStimulus(8'h20, 8'h00, 1'b0, 1'b0, 5);

    $display("[TB] edge channel 3");
    applyStimulus(8'h28, 8'h08, 1'b0, 1'b0, 1);
    applyStimulus(8'h20, 8'h08, 1'b0, 1'b0, 2);
    checkOutput("edge_pend", 1'b0, 0, 8'h08);
    applyStimulus(8'h20, 8'h08, 1'b0, 1'b0, 1);
    checkOutput("edge_irq", 1'b1, 3, 8'h08);
    applyStimulus(8'h20, 8'h08, 1'b1, 1'b0, 1);
    checkOutput("edge_claim", 1'b0, 3, 8'h08);
    applyStimulus(8'h20, 8'h08, 1'b0, 1'b1, 1);
    checkOutput("edge_done", 1'b0, 3, 8'h00);

    $display("[TB] level channel 5 active-low");
    applyStimulus(8'h00, 8'h20, 1'b0, 1'b0, 4);
    checkOutput("level_irq", 1'b1, 5, 8'h20);
    applyStimulus(8'h20, 8'h20, 1'b0, 1'b0, 4);
    checkOutput("level_drop", 1'b0, 5, 8'h00);

    $display("[TB] priority 6 then 1");
    applyStimulus(8'h60, 8'h42, 1'b0, 1'b0, 1);
    applyStimulus(8'h20, 8'h42, 1'b0, 1'b0, 3);
    checkOutput("prio_first", 1'b1, 6, 8'h40);
    applyStimulus(8'h22, 8'h42, 1'b0, 1'b0, 1);
    applyStimulus(8'h20, 8'h42, 1'b0, 1'b0, 2);
    checkOutput("prio_hold", 1'b1, 6, 8'h42);
    applyStimulus(8'h20, 8'h42, 1'b0, 1'b0, 1);
    checkOutput("prio_switch", 1'b1, 1, 8'h42);
    applyStimulus(8'h20, 8'h42, 1'b1, 1'b0, 1);
    applyStimulus(8'h20, 8'h42, 1'b0, 1'b1, 1);
    checkOutput("prio_done1", 1'b0, 1, 8'h40);
    applyStimulus(8'h20, 8'h42, 1'b0, 1'b0, 1);
    checkOutput("prio_back6", 1'b1, 6, 8'h40);
    applyStimulus(8'h20, 8'h42, 1'b1, 1'b0, 1);
    applyStimulus(8'h20, 8'h42, 1'b0, 1'b1, 1);
    checkOutput("prio_done6", 1'b0, 6, 8'h00);

    $display("[TB] masked channel 2");
    applyStimulus(8'h24, 8'h00, 1'b0, 1'b0, 1);
    applyStimulus(8'h20, 8'h00, 1'b0, 1'b0, 3);
    checkOutput("mask_hold", 1'b0, 6, 8'h04);
    applyStimulus(8'h20, 8'h04, 1'b0, 1'b0, 1);
    checkOutput("mask_open", 1'b1, 2, 8'h04);
    applyStimulus(8'h20, 8'h04, 1'b1, 1'b0, 1);
    applyStimulus(8'h20, 8'h04, 1'b0, 1'b1, 1);
    checkOutput("mask_done", 1'b0, 2, 8'h00);

    $display("[TB] new edge on complete");
    applyStimulus(8'h21, 8'h01, 1'b0, 1'b0, 1);
    applyStimulus(8'h20, 8'h01, 1'b0, 1'b0, 3);
    checkOutput("sw_irq", 1'b1, 0, 8'h01);
    applyStimulus(8'h20, 8'h01, 1'b1, 1'b0, 1);
    checkOutput("sw_claim", 1'b0, 0, 8'h01);
    applyStimulus(8'h21, 8'h01, 1'b0, 1'b0, 1);
    applyStimulus(8'h20, 8'h01, 1'b0, 1'b0, 1);
    applyStimulus(8'h20, 8'h01, 1'b0, 1'b1, 1);
    checkOutput("sw_keep", 1'b0, 0, 8'h01);
    applyStimulus(8'h20, 8'h01, 1'b0, 1'b0, 1);
    checkOutput("sw_reirq", 1'b1, 0, 8'h01);
    applyStimulus(8'h20, 8'h01, 1'b1, 1'b0, 1);
    applyStimulus(8'h20, 8'h01, 1'b0, 1'b1, 1);
    checkOutput("sw_done", 1'b0, 0, 8'h00);

    $display("[TB] reset mid-operation");
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, 4);
    rst = 1'b1;
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, 1);
    checkOutput("rst_mid", 1'b0, 0, 8'h00);
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, 1);
    checkOutput("rst_hold1", 1'b0, 0, 8'h00);
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, 1);
    checkOutput("rst_hold2", 1'b0, 0, 8'h00);
    rst = 1'b0;
    applyStimulus(8'h20, 8'h00, 1'b0, 1'b0, 6);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
